// File: rtl/clz_divider.sv
// clz_divider: 32-bit unsigned restoring divider whose iteration count is cut down using upstream CLZ counts.
// Optional feature macro CLZ_DIV_EARLY_EXIT_EN: align on both clz inputs and short-cut dividend < divisor.
module clz_divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [31:0] clz_dividend,
  input  logic [31:0] clz_divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ITER  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] dvd_r;
  logic [31:0] dvs_r;
  logic [31:0] rem_r;
  logic [31:0] q_r;
  logic [31:0] d_shift_r;
  logic [5:0]  clz_dvs_r;
  logic [5:0]  n_r;
  logic [5:0]  k_s;
  logic        early_exit_s;
  logic [31:0] rem_next_s;
  logic [31:0] q_next_s;

`ifdef CLZ_DIV_EARLY_EXIT_EN
  logic [5:0] clz_dvd_r;
  logic       unused_clz_s;
  assign unused_clz_s = ^{clz_dividend[31:6], clz_divisor[31:6]};

  // Shift distance lines the divisor MSB up with the dividend MSB; a shorter dividend finishes at once
  always_comb begin
    k_s = clz_dvs_r - clz_dvd_r;
    if (clz_dvd_r > clz_dvs_r) begin
      early_exit_s = 1'b1;
    end else begin
      early_exit_s = 1'b0;
    end
  end
`else
  logic unused_clz_s;
  assign unused_clz_s = ^{clz_dividend, clz_divisor[31:6]};

  // Without the dividend count the divisor is pushed all the way up to bit 31
  always_comb begin
    k_s          = clz_dvs_r;
    early_exit_s = 1'b0;
  end
`endif

  // One restoring-division step on the current partial remainder
  always_comb begin
    if (rem_r >= d_shift_r) begin
      rem_next_s = rem_r - d_shift_r;
      q_next_s   = {q_r[30:0], 1'b1};
    end else begin
      rem_next_s = rem_r;
      q_next_s   = {q_r[30:0], 1'b0};
    end
  end

  // Control FSM with registered results and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      dvd_r       <= 32'd0;
      dvs_r       <= 32'd0;
      rem_r       <= 32'd0;
      q_r         <= 32'd0;
      d_shift_r   <= 32'd0;
      clz_dvs_r   <= 6'd0;
      n_r         <= 6'd0;
`ifdef CLZ_DIV_EARLY_EXIT_EN
      clz_dvd_r   <= 6'd0;
`endif
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            dvd_r     <= dividend;
            dvs_r     <= divisor;
            clz_dvs_r <= clz_divisor[5:0];
`ifdef CLZ_DIV_EARLY_EXIT_EN
            clz_dvd_r <= clz_dividend[5:0];
`endif
            busy      <= 1'b1;
            state_r   <= ALIGN;
          end else begin
            state_r   <= IDLE;
          end
        end
        ALIGN: begin
          if (dvs_r == 32'd0) begin
            quotient    <= 32'hFFFF_FFFF;
            remainder   <= dvd_r;
            div_by_zero <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= DONE;
          end else if (early_exit_s) begin
            quotient    <= 32'd0;
            remainder   <= dvd_r;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= DONE;
          end else begin
            d_shift_r <= dvs_r << k_s;
            n_r       <= k_s + 6'd1;
            rem_r     <= dvd_r;
            q_r       <= 32'd0;
            state_r   <= ITER;
          end
        end
        ITER: begin
          rem_r     <= rem_next_s;
          q_r       <= q_next_s;
          d_shift_r <= d_shift_r >> 1;
          n_r       <= n_r - 6'd1;
          if (n_r == 6'd1) begin
            quotient    <= q_next_s;
            remainder   <= rem_next_s;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r     <= ITER;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clz_divider.sv
// Self-checking bench for clz_divider: directed vectors, randomized operands, reset and start-while-busy behaviour.
module tb_clz_divider;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] clz_dividend;
  logic [31:0] clz_divisor;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  clz_divider dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .clz_dividend (clz_dividend),
    .clz_divisor  (clz_divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clz32(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return 31 - i;
    end
    return 32;
  endfunction

  function automatic logic [31:0] exp_q(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 32'hFFFF_FFFF;
    return a / b;
  endfunction

  function automatic logic [31:0] exp_r(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return a;
    return a % b;
  endfunction

  // Done cycle counted with the start-sampling edge as edge 0
  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 2;
`ifdef CLZ_DIV_EARLY_EXIT_EN
    if (clz32(a) > clz32(b)) return 2;
    return clz32(b) - clz32(a) + 3;
`else
    if (a == 32'd0) return clz32(b) + 3;
    return clz32(b) + 3;
`endif
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit noise,
                       output logic [31:0] q, output logic [31:0] r, output logic dz,
                       output int lat, output bit chg);
    logic [31:0] q0, r0;
    logic        dz0;
    @(negedge clk);
    dividend     = a;
    divisor      = b;
    clz_dividend = 32'(clz32(a));
    clz_divisor  = 32'(clz32(b));
    start        = 1'b1;
    q0  = quotient;
    r0  = remainder;
    dz0 = div_by_zero;
    @(posedge clk); #1;
    start        = 1'b0;
    dividend     = $urandom;
    divisor      = $urandom;
    clz_dividend = 32'($urandom_range(0, 32));
    clz_divisor  = 32'($urandom_range(0, 32));
    lat = 0;
    chg = 1'b0;
    for (int j = 1; j <= 60; j++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = j + 1;
        break;
      end
      if (quotient !== q0 || remainder !== r0 || div_by_zero !== dz0) chg = 1'b1;
      if (noise) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat;
    reset_n      = 1'b0;
    start        = 1'b0;
    dividend     = 32'd0;
    divisor      = 32'd0;
    clz_dividend = 32'd0;
    clz_divisor  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0) begin
      $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dz=%b, expected all zero",
               quotient, remainder, busy, done, div_by_zero);
    end else pass_cnt++;
    // start is already high when reset releases, so the very next edge must take it
    dividend     = 32'd9;
    divisor      = 32'd3;
    clz_dividend = 32'(clz32(32'd9));
    clz_divisor  = 32'(clz32(32'd3));
    start        = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL first_start_accept: busy=%b, expected 1", busy);
    else pass_cnt++;
    lat = 0;
    for (int j = 1; j <= 60; j++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = j + 1;
        break;
      end
    end
    total_cnt++;
    if (lat != exp_lat(32'd9, 32'd3))
      $display("FAIL first_op_latency: got %0d, expected %0d", lat, exp_lat(32'd9, 32'd3));
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 32'd3 || remainder !== 32'd0 || div_by_zero !== 1'b0)
      $display("FAIL first_op_result: got q=%0d r=%0d dz=%b, expected q=3 r=0 dz=0",
               quotient, remainder, div_by_zero);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] av [6] = '{32'd100, 32'hFFFF_FFFF, 32'd5, 32'd3, 32'd0, 32'd7};
    logic [31:0] bv [6] = '{32'd7,   32'd1,         32'd0, 32'd10, 32'd9, 32'd7};
    logic [31:0] q, r;
    logic        dz;
    int          lat;
    bit          chg;
    for (int i = 0; i < 6; i++) begin
      do_op(av[i], bv[i], 1'b0, q, r, dz, lat, chg);
      total_cnt++;
      if (q !== exp_q(av[i], bv[i]) || r !== exp_r(av[i], bv[i]))
        $display("FAIL directed_result[%0d]: %0d/%0d got q=%h r=%h, expected q=%h r=%h", i, av[i], bv[i],
                 q, r, exp_q(av[i], bv[i]), exp_r(av[i], bv[i]));
      else pass_cnt++;
      total_cnt++;
      if (dz !== (bv[i] == 32'd0))
        $display("FAIL directed_dz[%0d]: got %b, expected %b", i, dz, (bv[i] == 32'd0));
      else pass_cnt++;
      total_cnt++;
      if (lat != exp_lat(av[i], bv[i]))
        $display("FAIL directed_latency[%0d]: got %0d, expected %0d", i, lat, exp_lat(av[i], bv[i]));
      else pass_cnt++;
      total_cnt++;
      if (chg !== 1'b0) $display("FAIL directed_hold[%0d]: outputs changed before done", i);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r;
    logic        dz;
    int          lat;
    bit          chg;
    for (int i = 0; i < 24; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      case (i % 4)
        0:       b = 32'($urandom_range(1, 255));
        1:       b = $urandom >> $urandom_range(0, 31);
        2:       b = (i % 8 == 2) ? 32'd0 : $urandom;
        default: b = 32'd1 << $urandom_range(0, 31);
      endcase
      do_op(a, b, 1'b1, q, r, dz, lat, chg);
      total_cnt++;
      if (q !== exp_q(a, b) || r !== exp_r(a, b))
        $display("FAIL random_result[%0d]: %h/%h got q=%h r=%h, expected q=%h r=%h", i, a, b,
                 q, r, exp_q(a, b), exp_r(a, b));
      else pass_cnt++;
      total_cnt++;
      if (dz !== (b == 32'd0)) $display("FAIL random_dz[%0d]: got %b, expected %b", i, dz, (b == 32'd0));
      else pass_cnt++;
      total_cnt++;
      if (lat != exp_lat(a, b))
        $display("FAIL random_latency[%0d]: got %0d, expected %0d", i, lat, exp_lat(a, b));
      else pass_cnt++;
      total_cnt++;
      if (chg !== 1'b0) $display("FAIL random_hold[%0d]: outputs changed before done", i);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] q, r;
    logic        dz;
    int          lat;
    bit          chg;
    int          extra;
    do_op(32'd100, 32'd7, 1'b0, q, r, dz, lat, chg);
    @(negedge clk);
    dividend     = 32'd100;
    divisor      = 32'd7;
    clz_dividend = 32'd25;
    clz_divisor  = 32'd29;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 67'd0)
      $display("FAIL midop_reset: got q=%h r=%h busy=%b done=%b dz=%b, expected all zero",
               quotient, remainder, busy, done, div_by_zero);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    do_op(32'd9, 32'd3, 1'b1, q, r, dz, lat, chg);
    total_cnt++;
    if (q !== 32'd3 || r !== 32'd0 || dz !== 1'b0)
      $display("FAIL after_reset_result: got q=%0d r=%0d dz=%b, expected q=3 r=0 dz=0", q, r, dz);
    else pass_cnt++;
    total_cnt++;
    if (lat != exp_lat(32'd9, 32'd3))
      $display("FAIL after_reset_latency: got %0d, expected %0d", lat, exp_lat(32'd9, 32'd3));
    else pass_cnt++;
    extra = 0;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    total_cnt++;
    if (extra != 0) $display("FAIL busy_start_ignored: got %0d active cycles after done, expected 0", extra);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/clz_divider.md
CLZ_DIVIDER -- requirements
Module: clz_divider

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL change on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; SHALL be sampled only in IDLE.
REQ-005 dividend  input  32  unsigned numerator.
REQ-006 divisor  input  32  unsigned denominator.
REQ-007 clz_dividend  input  32  leading-zero count of dividend (0..32) from upstream CLZ unit; SHALL use bits [5:0] only.
REQ-008 clz_divisor  input  32  leading-zero count of divisor (0..32); SHALL use bits [5:0] only.
REQ-009 quotient  output  32  registered result.
REQ-010 remainder  output  32  registered result.
REQ-011 busy  output  1  high in ALIGN and ITER.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 div_by_zero  output  1  registered flag for the last completed operation.

Function
REQ-014 FSM SHALL have states IDLE, ALIGN, ITER, DONE.
REQ-015 IDLE: start=1 at an edge SHALL latch dividend, divisor and both clz values, then go to ALIGN.
REQ-016 ALIGN, divisor==0: SHALL go to DONE with quotient=0xFFFFFFFF, remainder=dividend, div_by_zero=1.
REQ-017 ALIGN, clz_dividend>clz_divisor (with CLZ_DIV_EARLY_EXIT_EN): SHALL go to DONE with quotient=0, remainder=dividend, div_by_zero=0.
REQ-018 ALIGN, otherwise: SHALL load d_shift=divisor<<k and n=k+1, partial remainder=dividend, partial quotient=0, then go to ITER; k=clz_divisor-clz_dividend with macro, k=clz_divisor without.
REQ-019 Each ITER cycle: if rem>=d_shift then rem-=d_shift and q=(q<<1)|1, else q=q<<1; then d_shift>>=1 and n decrements.
REQ-020 ITER SHALL last exactly n cycles, then go to DONE with quotient=q, remainder=rem, div_by_zero=0.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 Latency: with start sampled at edge E0, done SHALL be high in cycle n+2 for iterating operations and in cycle 2 for short-cut cases.
REQ-023 quotient, remainder and div_by_zero SHALL change only on entry to DONE and hold until the next completion.
REQ-024 start in ALIGN, ITER or DONE SHALL be ignored.
REQ-025 Operand input changes after acceptance SHALL have no effect.
REQ-026 clz input values above 32 are illegal; behaviour for them is undefined.

Reset
REQ-027 reset_n low SHALL immediately force IDLE and set quotient, remainder, busy, done, div_by_zero and all internal registers to 0, including mid-operation.
REQ-028 The first start SHALL be accepted at the first edge after reset_n rises.

Configuration
REQ-029 Macro CLZ_DIV_EARLY_EXIT_EN defined: alignment SHALL use both clz inputs and the REQ-017 short-cut SHALL apply.
REQ-030 Macro CLZ_DIV_EARLY_EXIT_EN undefined: clz_dividend SHALL be ignored, the REQ-017 short-cut SHALL be absent, and latency SHALL depend only on divisor; results SHALL be identical in both builds.

Verification
REQ-031 100/7 (clz 25/29), macro on -> n=5; done in cycle 7; quotient=14, remainder=2, div_by_zero=0.
REQ-032 0xFFFFFFFF/1 (clz 0/31) -> n=32; done in cycle 34; quotient=0xFFFFFFFF, remainder=0.
REQ-033 5/0 -> done in cycle 2; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-034 3/10 (clz 30/28), macro on -> done in cycle 2; quotient=0, remainder=3; 0/9 -> quotient=0, remainder=0.
REQ-035 100/7, macro off -> n=30; done in cycle 32; quotient=14, remainder=2.
REQ-036 reset_n pulsed low during ITER of 100/7 -> all outputs 0 asynchronously; new 9/3 -> quotient=3, remainder=0; start pulses while busy produce no extra done.
